node_scheduler: RTL and testbench

Time-multiplexed controller that shares one leaky integrate-and-fire datapath among `N_NODES` virtual neurons. On each `tick` it sweeps all nodes round-robin, one node per clock. For each node it applies `next = current + (state >> 1)`, stores the result and compares it against that node's programmable threshold. It sits between the network-level tick/current source and the spike fabric, and replaces per-neuron node instances with a single shared datapath plus state/threshold register files.

---
 rtl/node_scheduler_pkg.sv | 34 +++
 rtl/node_scheduler_if.sv | 35 +++
 rtl/node_scheduler_datapath.sv | 26 ++
 rtl/node_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_node_scheduler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/node_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// node_pkg
// Shared definitions for the time-multiplexed leaky integrate-and-fire
// scheduler: FSM state encoding, default width / threshold constants and the
// saturating add-and-leak arithmetic used by the shared datapath.
// ---------------------------------------------------------------------------
package node_pkg;

    localparam int NODE_W          = 8;
    localparam int NODE_THRESH_RST = 32;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_EVAL = 2'd1,
        FSM_DONE = 2'd2
    } fsm_e;

    // next = cur + (st >> 1), computed one bit wider than w and clamped to
    // 2^w - 1. Operands are zero-extended to 32 bits so any w <= 31 fits.
    function automatic logic [31:0] sat_add_leak(input logic [31:0] cur,
                                                 input logic [31:0] st,
                                                 input int          w);
        logic [32:0] sum_s;
        logic [32:0] max_s;
        sum_s = {1'b0, cur} + {2'b00, st[31:1]};
        max_s = (33'd1 << w) - 33'd1;
        if (sum_s > max_s) begin
            return max_s[31:0];
        end else begin
            return sum_s[31:0];
        end
    endfunction

endpackage

// File: rtl/node_scheduler_if.sv
// ---------------------------------------------------------------------------
// node_scheduler_if
// Bundles the tick/current input, threshold configuration port, debug read
// port and status outputs of node_scheduler.
//   master : drives tick, current_in, cfg_*, rd_addr; observes results
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface node_scheduler_if #(
    parameter int N_NODES = 4,
    parameter int W       = 8
);
    localparam int IDX_W = $clog2(N_NODES);

    logic                   tick;
    logic [N_NODES*W-1:0]   current_in;
    logic                   cfg_we;
    logic [IDX_W-1:0]       cfg_addr;
    logic [W-1:0]           cfg_thresh;
    logic [IDX_W-1:0]       rd_addr;
    logic [W-1:0]           rd_state;
    logic [N_NODES-1:0]     spikes;
    logic                   busy;
    logic                   done;
    logic                   overrun;

    modport master (
        output tick, current_in, cfg_we, cfg_addr, cfg_thresh, rd_addr,
        input  rd_state, spikes, busy, done, overrun
    );

    modport slave (
        input  tick, current_in, cfg_we, cfg_addr, cfg_thresh, rd_addr,
        output rd_state, spikes, busy, done, overrun
    );
endinterface

// File: rtl/node_scheduler_datapath.sv
// ---------------------------------------------------------------------------
// node_datapath
// Combinational leaky integrate-and-fire step for one node.
//   cur    : input current of the node
//   state  : stored membrane state of the node
//   thresh : spike threshold of the node
//   sum    : saturated cur + (state >> 1)
//   spike  : sum >= thresh (unsigned)
// ---------------------------------------------------------------------------
module node_datapath
    import node_pkg::*;
#(
    parameter int W = NODE_W
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] state,
    input  logic [W-1:0] thresh,
    output logic [W-1:0] sum,
    output logic         spike
);

    // Result never exceeds 2^W - 1, so the truncating cast is lossless.
    assign sum   = W'(sat_add_leak(32'(cur), 32'(state), W));
    assign spike = (sum >= thresh);

endmodule

// File: rtl/node_scheduler.sv
// ---------------------------------------------------------------------------
// node_scheduler
// Shares one node_datapath among N_NODES virtual neurons. A tick accepted in
// IDLE captures all currents and sweeps the nodes one per clock; the spike
// vector is published when the last node has been evaluated.
// Ports:
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : node_scheduler_if slave (tick/current, threshold config,
//              debug state read, spikes/busy/done/overrun status)
// Build option: NODE_SCHED_REFRACTORY_EN adds per-node refractory counters
// (state forced to 0 and spikes suppressed for REFRAC_TICKS sweeps after a
// spike).
// ---------------------------------------------------------------------------
module node_scheduler
    import node_pkg::*;
#(
    parameter int N_NODES      = 4,
    parameter int W            = NODE_W,
    parameter int REFRAC_TICKS = 2
) (
    input  logic              clk,
    input  logic              rst,
    node_scheduler_if.slave   bus
);

    localparam int         IDX_W  = $clog2(N_NODES);
    localparam logic [1:0] S_IDLE = FSM_IDLE;
    localparam logic [1:0] S_EVAL = FSM_EVAL;
    localparam logic [1:0] S_DONE = FSM_DONE;

    logic [1:0]                  fsm_r;
    logic [1:0]                  fsm_nx_s;
    logic [IDX_W-1:0]            idx_r;
    logic [N_NODES-1:0][W-1:0]   cur_r;
    logic [W-1:0]                st_r [N_NODES];
    logic [W-1:0]                th_r [N_NODES];
    logic [N_NODES-1:0]          acc_r;
    logic [N_NODES-1:0]          spikes_r;
    logic [N_NODES-1:0]          spikes_fin_s;
    logic                        busy_r;
    logic                        done_r;
    logic                        overrun_r;
    logic                        last_s;
    logic [W-1:0]                sum_s;
    logic                        spike_raw_s;
    logic [W-1:0]                st_wr_s;
    logic                        spike_s;
    logic [W-1:0]                rd_state_s;

`ifdef NODE_SCHED_REFRACTORY_EN
    localparam int RC_W = $clog2(REFRAC_TICKS + 1) + 1;
    logic [RC_W-1:0]             rc_r [N_NODES];
    logic [RC_W-1:0]             rc_nx_s;
`endif

    assign last_s = (idx_r == IDX_W'(N_NODES - 1));

    node_datapath #(.W(W)) u_dp (
        .cur    (cur_r[idx_r]),
        .state  (st_r[idx_r]),
        .thresh (th_r[idx_r]),
        .sum    (sum_s),
        .spike  (spike_raw_s)
    );

    // Value written back and spike recorded for the node under evaluation.
    always_comb begin
        st_wr_s = sum_s;
        spike_s = spike_raw_s;
`ifdef NODE_SCHED_REFRACTORY_EN
        rc_nx_s = rc_r[idx_r];
        if (rc_r[idx_r] != '0) begin
            st_wr_s = '0;
            spike_s = 1'b0;
            rc_nx_s = rc_r[idx_r] - RC_W'(1);
        end else if (spike_raw_s) begin
            st_wr_s = '0;
            rc_nx_s = RC_W'(REFRAC_TICKS);
        end else begin
            rc_nx_s = rc_r[idx_r];
        end
`endif
    end

    // Final spike vector: accumulated bits with the last node's result merged.
    always_comb begin
        spikes_fin_s        = acc_r;
        spikes_fin_s[idx_r] = spike_s;
    end

    // FSM next-state decode.
    always_comb begin
        fsm_nx_s = fsm_r;
        case (fsm_r)
            S_IDLE: begin
                if (bus.tick) begin
                    fsm_nx_s = S_EVAL;
                end else begin
                    fsm_nx_s = S_IDLE;
                end
            end
            S_EVAL: begin
                if (last_s) begin
                    fsm_nx_s = S_DONE;
                end else begin
                    fsm_nx_s = S_EVAL;
                end
            end
            S_DONE:  fsm_nx_s = S_IDLE;
            default: fsm_nx_s = S_IDLE;
        endcase
    end

    // FSM, sweep index, captured currents and status/spike output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r    <= S_IDLE;
            idx_r    <= '0;
            cur_r    <= '0;
            acc_r    <= '0;
            spikes_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            fsm_r  <= fsm_nx_s;
            busy_r <= (fsm_nx_s != S_IDLE);
            done_r <= (fsm_r == S_EVAL) && last_s;
            case (fsm_r)
                S_IDLE: begin
                    if (bus.tick) begin
                        cur_r <= bus.current_in;
                        idx_r <= '0;
                    end
                end
                S_EVAL: begin
                    acc_r[idx_r] <= spike_s;
                    if (last_s) begin
                        idx_r    <= '0;
                        spikes_r <= spikes_fin_s;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

    // State register file (plus refractory counters): written by evaluation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NODES; i++) begin
                st_r[i] <= '0;
`ifdef NODE_SCHED_REFRACTORY_EN
                rc_r[i] <= '0;
`endif
            end
        end else if (fsm_r == S_EVAL) begin
            st_r[idx_r] <= st_wr_s;
`ifdef NODE_SCHED_REFRACTORY_EN
            rc_r[idx_r] <= rc_nx_s;
`endif
        end
    end

    // Threshold register file: writable in any state; out-of-range ignored.
    // A same-cycle write to the node being evaluated only affects later sweeps
    // because the datapath reads the registered value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NODES; i++) begin
                th_r[i] <= W'(NODE_THRESH_RST);
            end
        end else if (bus.cfg_we && ({1'b0, bus.cfg_addr} < (IDX_W + 1)'(N_NODES))) begin
            th_r[bus.cfg_addr] <= bus.cfg_thresh;
        end
    end

    // Sticky overrun flag: a tick that arrives outside IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (bus.tick && (fsm_r != S_IDLE)) begin
            overrun_r <= 1'b1;
        end
    end

    // Debug read port is combinational by design.
    always_comb begin
        if ({1'b0, bus.rd_addr} < (IDX_W + 1)'(N_NODES)) begin
            rd_state_s = st_r[bus.rd_addr];
        end else begin
            rd_state_s = '0;
        end
    end

    assign bus.rd_state = rd_state_s;
    assign bus.spikes   = spikes_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_node_scheduler.sv
// ---------------------------------------------------------------------------
// tb_node_scheduler
// Self-checking bench for node_scheduler (N_NODES=4, W=8): a table of sweep
// vectors with constant expectations, hand-written corner sequences, and a
// randomized phase compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_node_scheduler;

    localparam int N   = 4;
    localparam int WW  = 8;
    localparam int REF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    node_scheduler_if #(.N_NODES(N), .W(WW)) bus ();

    node_scheduler #(.N_NODES(N), .W(WW), .REFRAC_TICKS(REF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: per-node state, threshold, refractory count
    int m_st [N];
    int m_th [N];
    int m_rc [N];

    typedef struct {
        logic        rst_before;
        logic        wr_en;
        logic [1:0]  wr_addr;
        logic [7:0]  wr_val;
        logic [31:0] cur;
        logic [31:0] exp_state;
        logic [3:0]  exp_spikes;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0;
            m_th[i] = 32;
            m_rc[i] = 0;
        end
    endtask

    task automatic model_sweep(input logic [31:0] cur, output logic [3:0] sp);
        int s;
        for (int i = 0; i < N; i++) begin
            s = int'(cur[i*8 +: 8]) + m_st[i] / 2;
            if (s > 255) s = 255;
`ifdef NODE_SCHED_REFRACTORY_EN
            if (m_rc[i] > 0) begin
                sp[i] = 1'b0; m_st[i] = 0; m_rc[i]--;
            end else if (s >= m_th[i]) begin
                sp[i] = 1'b1; m_st[i] = 0; m_rc[i] = REF;
            end else begin
                sp[i] = 1'b0; m_st[i] = s;
            end
`else
            sp[i]   = (s >= m_th[i]);
            m_st[i] = s;
`endif
        end
    endtask

    task automatic do_reset();
        bus.tick = 1'b0; bus.cfg_we = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic read_states(output logic [31:0] v);
        for (int i = 0; i < N; i++) begin
            bus.rd_addr = 2'(i);
            #1 v[i*8 +: 8] = bus.rd_state;
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_thresh = d;
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
        m_th[a] = int'(d);
    endtask

    // Full sweep from tick to IDLE; optional threshold write sampled at edge
    // E(wc) (wc=0: none). Checks busy after E0, done only at E4, busy low
    // after E5. Current input is scrambled after E0.
    task automatic sweep(input logic [31:0] cur, input int wc,
                         input logic [1:0] wa, input logic [7:0] wd);
        logic done_ok;
        bus.tick = 1'b1; bus.current_in = cur;
        @(posedge clk);
        #1 bus.tick = 1'b0; bus.current_in = $urandom;
        check("busy_after_tick", 32'(bus.busy), 32'd1);
        if (wc == 1) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = wa; bus.cfg_thresh = wd;
        end
        done_ok = 1'b1;
        for (int c = 1; c <= N + 1; c++) begin
            @(posedge clk);
            #1 bus.cfg_we = 1'b0;
            if (c + 1 == wc) begin
                bus.cfg_we = 1'b1; bus.cfg_addr = wa; bus.cfg_thresh = wd;
            end
            if (bus.done !== (c == N)) done_ok = 1'b0;
        end
        check("done_timing", 32'(done_ok), 32'd1);
        check("busy_end", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] st;
        logic [3:0]  sp;
        int          dcnt;
        int          got;

        vecs[0] = '{1'b1, 1'b0, 2'd0, 8'd0,  32'h0000_0000, 32'h0000_0000, 4'b0000};
        vecs[1] = '{1'b0, 1'b0, 2'd0, 8'd0,  32'h1010_1010, 32'h1010_1010, 4'b0000};
        vecs[2] = '{1'b0, 1'b0, 2'd0, 8'd0,  32'h1010_1010, 32'h1818_1818, 4'b0000};
        vecs[3] = '{1'b0, 1'b0, 2'd0, 8'd0,  32'h1010_1010, 32'h1c1c_1c1c, 4'b0000};
        vecs[4] = '{1'b0, 1'b0, 2'd0, 8'd0,  32'h1010_1010, 32'h1e1e_1e1e, 4'b0000};
`ifdef NODE_SCHED_REFRACTORY_EN
        vecs[5] = '{1'b0, 1'b1, 2'd2, 8'd30, 32'h1010_1010, 32'h1f00_1f1f, 4'b0100};
        vecs[6] = '{1'b1, 1'b0, 2'd0, 8'd0,  32'h0000_00f0, 32'h0000_0000, 4'b0001};
        vecs[7] = '{1'b0, 1'b0, 2'd0, 8'd0,  32'h0000_00f0, 32'h0000_0000, 4'b0000};
`else
        vecs[5] = '{1'b0, 1'b1, 2'd2, 8'd30, 32'h1010_1010, 32'h1f1f_1f1f, 4'b0100};
        vecs[6] = '{1'b1, 1'b0, 2'd0, 8'd0,  32'h0000_00f0, 32'h0000_00f0, 4'b0001};
        vecs[7] = '{1'b0, 1'b0, 2'd0, 8'd0,  32'h0000_00f0, 32'h0000_00ff, 4'b0001};
`endif

        bus.tick = 1'b0; bus.current_in = '0; bus.cfg_we = 1'b0;
        bus.cfg_addr = '0; bus.cfg_thresh = '0; bus.rd_addr = '0;

        // reset state
        do_reset();
        check("rst_spikes",  32'(bus.spikes),  32'd0);
        check("rst_busy",    32'(bus.busy),    32'd0);
        check("rst_done",    32'(bus.done),    32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        read_states(st);
        check("rst_states", st, 32'd0);

        // table-driven sweeps: convergence, threshold write, saturation
        for (int k = 0; k < 8; k++) begin
            if (vecs[k].rst_before) do_reset();
            if (vecs[k].wr_en) cfg_write(vecs[k].wr_addr, vecs[k].wr_val);
            sweep(vecs[k].cur, 0, 2'd0, 8'd0);
            check($sformatf("vec%0d_spikes", k), 32'(bus.spikes), 32'(vecs[k].exp_spikes));
            read_states(st);
            check($sformatf("vec%0d_state", k), st, vecs[k].exp_state);
        end

        // overrun: tick at E0 and E2, then an accepted tick at E6
        do_reset();
        bus.tick = 1'b1; bus.current_in = '0;
        @(posedge clk);
        #1 bus.tick = 1'b0;
        dcnt = 0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1 if (bus.done) dcnt++;
            if (c == 1) bus.tick = 1'b1;
            if (c == 2) bus.tick = 1'b0;
            if (c == 5) bus.tick = 1'b1;
        end
        @(posedge clk);
        #1 bus.tick = 1'b0;
        check("ovr_done_count", 32'(dcnt), 32'd1);
        check("ovr_flag", 32'(bus.overrun), 32'd1);
        check("ovr_retick_busy", 32'(bus.busy), 32'd1);
        got = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1 if (bus.done && got == 0) got = c;
        end
        check("ovr_retick_done_cycle", 32'(got), 32'd4);
        check("ovr_sticky", 32'(bus.overrun), 32'd1);

        // same-cycle threshold write on the node under evaluation (node 1 at E2)
        do_reset();
        sweep(32'h0000_2800, 2, 2'd1, 8'd255);
        check("samecyc_spikes", 32'(bus.spikes), 32'b0010);
        sweep(32'h0000_2800, 0, 2'd0, 8'd0);
        check("newthr_spikes", 32'(bus.spikes), 32'b0000);
        read_states(st);
`ifdef NODE_SCHED_REFRACTORY_EN
        check("newthr_state", st, 32'h0000_0000);
`else
        check("newthr_state", st, 32'h0000_3c00);
`endif

        // reset mid-sweep after E2
        do_reset();
        sweep(32'h2828_2828, 0, 2'd0, 8'd0);
        check("pre_rst_spikes", 32'(bus.spikes), 32'hf);
        bus.tick = 1'b1; bus.current_in = 32'h2828_2828;
        repeat (3) @(posedge clk);
        bus.tick = 1'b0;
        #1 rst = 1'b1;
        #1 check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_spikes", 32'(bus.spikes), 32'd0);
        read_states(st);
        check("midrst_states", st, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // randomized sweeps vs. reference model
        for (int r = 0; r < 24; r++) begin
            logic [31:0] cur;
            if ($urandom_range(0, 2) == 0)
                cfg_write(2'($urandom_range(0, 3)), 8'($urandom_range(8, 200)));
            for (int i = 0; i < N; i++) cur[i*8 +: 8] = 8'($urandom_range(0, 90));
            if (r == 10) cur[7:0] = 8'hff;
            model_sweep(cur, sp);
            sweep(cur, 0, 2'd0, 8'd0);
            check($sformatf("rnd%0d_spikes", r), 32'(bus.spikes), 32'(sp));
            read_states(st);
            for (int i = 0; i < N; i++)
                check($sformatf("rnd%0d_state%0d", r, i), 32'(st[i*8 +: 8]), 32'(m_st[i]));
        end

`ifdef NODE_SCHED_REFRACTORY_EN
        // refractory: current 40, threshold 32
        do_reset();
        for (int s = 1; s <= 4; s++) begin
            sweep(32'h0000_0028, 0, 2'd0, 8'd0);
            check($sformatf("refr%0d_spike", s), 32'(bus.spikes[0]), 32'((s == 1) || (s == 4)));
            read_states(st);
            check($sformatf("refr%0d_state", s), 32'(st[7:0]), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
